mesh_unloader: RTL and testbench

- Downstream of the subdivision engine: once the engine finishes, this block reads the refined mesh out of one quadram port.
- The mesh is a contiguous block of 32-bit words.
- The words leave as a valid/ready stream toward the host/output interface.
- Decouples RAM read latency from output backpressure with a small internal FIFO; sustains 1 word/cycle when the sink never stalls.

---
 rtl/mesh_unloader.sv | 194 +++++++++++++++++++
 tb/tb_mesh_unloader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_unloader.sv
// mesh_unloader: reads a contiguous block of 32-bit quadram words and streams them out
// over valid/ready. Define UNLOADER_CHECKSUM_EN to append a 32-bit sum beat after the data.
module mesh_unloader #(
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_dout,
  output logic                  m_valid,
  output logic [31:0]           m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  active,
  output logic                  done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]           DEPTH_V   = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]         COUNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DRAIN  = 3'd2,
    CSUM   = 3'd3,
    FINISH = 3'd4
  } state_t;

`ifdef UNLOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = FINISH;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_left;
  logic [ADDR_WIDTH:0]   beat_left;
  logic                  inflight;
  logic [31:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_valid;
  logic                  pop;
  logic                  last_pop;
  logic                  issue;
  logic [CW:0]           outstanding;
  logic [31:0]           head;

  assign ram_we      = 4'b0000;
  assign fifo_valid  = (count != {CW{1'b0}});
  assign head        = mem[rd_ptr];
  assign pop         = fifo_valid & m_ready;
  assign last_pop    = pop && (beat_left == CNT_ONE);
  // Reads already issued but not yet in the FIFO reserve a slot, so the FIFO can never overflow.
  assign outstanding = {1'b0, count} + {{CW{1'b0}}, ram_en} + {{CW{1'b0}}, inflight};
  assign issue       = (state == READ) && (rd_left != CNT_ZERO) && (outstanding < DEPTH_V);

`ifdef UNLOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_beat;

  assign sum_beat = (state == CSUM);
  assign m_valid  = fifo_valid | sum_beat;
  assign m_data   = sum_beat ? sum : (fifo_valid ? head : 32'h0000_0000);
  assign m_last   = sum_beat;

  // Running sum of every popped data beat, cleared on each accepted go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 32'h0000_0000;
    end else if (state == IDLE && go) begin
      sum <= 32'h0000_0000;
    end else if (pop) begin
      sum <= sum + head;
    end
  end
`else
  assign m_valid = fifo_valid;
  assign m_data  = fifo_valid ? head : 32'h0000_0000;
  assign m_last  = fifo_valid && (beat_left == CNT_ONE);
`endif

  // Control FSM with the read-issue pipeline and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= {ADDR_WIDTH{1'b0}};
      rd_left   <= CNT_ZERO;
      beat_left <= CNT_ZERO;
      ram_en    <= 1'b0;
      ram_addr  <= {ADDR_WIDTH{1'b0}};
      inflight  <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_en   <= issue;
      inflight <= ram_en;
      if (issue) begin
        ram_addr <= rd_addr;
        rd_addr  <= rd_addr + ADDR_ONE;
        rd_left  <= rd_left - CNT_ONE;
      end
      if (pop) begin
        beat_left <= beat_left - CNT_ONE;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            rd_addr   <= base_addr;
            rd_left   <= word_count;
            beat_left <= word_count;
            active    <= 1'b1;
            if (word_count == CNT_ZERO) begin
              state <= TAIL;
              done  <= (TAIL == FINISH);
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (issue && rd_left == CNT_ONE) begin
            state <= DRAIN;
          end
        end
        // Leave on the final handshake so done lands in the very next cycle.
        DRAIN: begin
          if (last_pop || beat_left == CNT_ZERO) begin
            state <= TAIL;
            done  <= (TAIL == FINISH);
          end
        end
        CSUM: begin
          if (m_ready) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done   <= 1'b0;
          active <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done   <= 1'b0;
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a push is the read data arriving the cycle after ram_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (inflight) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({inflight, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (inflight) begin
      mem[wr_ptr] <= ram_dout;
    end
  end
endmodule

// File: tb/tb_mesh_unloader.sv
// Directed self-checking bench for mesh_unloader with a behavioural registered-read quadram.
module tb_mesh_unloader;
  localparam int AW    = 11;
  localparam int DEPTH = 4;
`ifdef UNLOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_dout;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          active;
  logic          done;

  logic [31:0] ram [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cyc = 0;

  logic [31:0]   bq_data[$];
  logic          bq_last[$];
  int            bq_cyc[$];
  logic [AW-1:0] aq[$];
  int issued = 0, popped = 0, max_out = 0, done_cnt = 0, done_cyc = 0;
  int stall_viol = 0, we_viol = 0;

  mesh_unloader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .word_count(word_count),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .active(active), .done(done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) ram_dout <= ram[ram_addr];
  end

  // Negedge monitor: logs handshakes, issued addresses, stalls and done pulses.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_we !== 4'h0) we_viol++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
          stall_viol++;
        if (ram_en) begin
          issued++;
          aq.push_back(ram_addr);
        end
        if (issued - popped > max_out) max_out = issued - popped;
        if (m_valid && m_ready) begin
          bq_data.push_back(m_data);
          bq_last.push_back(m_last);
          bq_cyc.push_back(cyc);
          popped++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_log();
    bq_data.delete(); bq_last.delete(); bq_cyc.delete(); aq.delete();
    issued = 0; popped = 0; max_out = 0; stall_viol = 0;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk); #1;
    go = 1'b1; base_addr = b; word_count = n;
    go_cyc = cyc + 1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic run(input int limit, input logic [15:0] pat, output bit ok);
    int start_done;
    start_done = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      m_ready = pat[i % 16];
      if (done_cnt != start_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_addr, m_valid, m_last, m_data, active, done} !== 48'h0)
      begin errors++; $display("FAIL reset_outputs: got %h expected 0", {ram_en, ram_addr, m_valid, m_last, m_data, active, done}); end
    checks++;
    if (ram_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h expected 0", ram_we); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_en, m_valid, active, done} !== 4'h0)
      begin errors++; $display("FAIL idle_outputs: got %b expected 0000", {ram_en, m_valid, active, done}); end
  endtask

  task automatic test_zero();
    bit ok;
    clear_log(); m_ready = 1'b1;
    start(11'h000, 12'h000);
    run(20, 16'hFFFF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_done: got timeout expected done pulse"); end
    checks++;
    if (bq_data.size() != CS) begin errors++; $display("FAIL zero_beats: got %0d expected %0d", bq_data.size(), CS); end
    for (int i = 0; i < bq_data.size(); i++) begin
      checks++;
      if (bq_data[i] !== 32'h0 || bq_last[i] !== 1'b1)
        begin errors++; $display("FAIL zero_sum_beat: got %h/%b expected 0/1", bq_data[i], bq_last[i]); end
    end
    checks++;
    if (done_cyc != go_cyc + CS) begin errors++; $display("FAIL zero_done_cyc: got %0d expected %0d", done_cyc, go_cyc + CS); end
    checks++;
    if (issued != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", issued); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL zero_active: got %b expected 0", active); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) ram[16 + i] = 32'hA000_0000 + i;
    clear_log(); m_ready = 1'b1;
    start(11'h010, 12'd8);
    run(60, 16'hFFFF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got timeout expected done pulse"); end
    checks++;
    if (bq_data.size() != 8 + CS) begin errors++; $display("FAIL basic_beats: got %0d expected %0d", bq_data.size(), 8 + CS); end
    for (int i = 0; i < bq_data.size() && i < 8 + CS; i++) begin
      exp = (i < 8) ? 32'hA000_0000 + i : 32'h0000_001C;
      checks++;
      if (bq_data[i] !== exp || bq_last[i] !== (i == 7 + CS) || bq_cyc[i] != go_cyc + 3 + i)
        begin errors++; $display("FAIL basic_beat%0d: got %h/%b@%0d expected %h/%b@%0d", i, bq_data[i], bq_last[i], bq_cyc[i], exp, (i == 7 + CS), go_cyc + 3 + i); end
    end
    checks++;
    if (done_cyc != go_cyc + 11 + CS) begin errors++; $display("FAIL basic_done_cyc: got %0d expected %0d", done_cyc, go_cyc + 11 + CS); end
    checks++;
    if (aq.size() != 8) begin errors++; $display("FAIL basic_reads: got %0d expected 8", aq.size()); end
    for (int i = 0; i < aq.size() && i < 8; i++) begin
      checks++;
      if (aq[i] !== 11'h010 + i) begin errors++; $display("FAIL basic_addr%0d: got %h expected %h", i, aq[i], 11'h010 + i); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp;
    int n;
    clear_log(); m_ready = 1'b0;
    start(11'h010, 12'd8);
    run(300, 16'b1010_0110_1100_0101, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: got timeout expected done pulse"); end
    n = bq_data.size();
    checks++;
    if (n != 8 + CS) begin errors++; $display("FAIL bp_beats: got %0d expected %0d", n, 8 + CS); end
    for (int i = 0; i < n && i < 8 + CS; i++) begin
      exp = (i < 8) ? 32'hA000_0000 + i : 32'h0000_001C;
      checks++;
      if (bq_data[i] !== exp || bq_last[i] !== (i == 7 + CS))
        begin errors++; $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, bq_data[i], bq_last[i], exp, (i == 7 + CS)); end
    end
    checks++;
    if (n > 0 && done_cyc != bq_cyc[n-1] + 1) begin errors++; $display("FAIL bp_done_cyc: got %0d expected %0d", done_cyc, bq_cyc[n-1] + 1); end
    checks++;
    if (max_out > DEPTH) begin errors++; $display("FAIL bp_outstanding: got %0d expected <= %0d", max_out, DEPTH); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stall_viol); end
    m_ready = 1'b1;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0]   exp;
    logic [AW-1:0] ea;
    logic [31:0]   vals [4];
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222; vals[2] = 32'h3333_3333; vals[3] = 32'h4444_4444;
    ram[11'h7FE] = vals[0]; ram[11'h7FF] = vals[1]; ram[11'h000] = vals[2]; ram[11'h001] = vals[3];
    clear_log(); m_ready = 1'b1;
    start(11'h7FE, 12'd4);
    run(40, 16'hFFFF, ok);
    checks++;
    if (!ok || aq.size() != 4) begin errors++; $display("FAIL wrap_reads: got %0d reads done=%b expected 4", aq.size(), ok); end
    for (int i = 0; i < aq.size() && i < 4; i++) begin
      ea = 11'h7FE + i;
      checks++;
      if (aq[i] !== ea) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, aq[i], ea); end
    end
    checks++;
    if (bq_data.size() != 4 + CS) begin errors++; $display("FAIL wrap_beats: got %0d expected %0d", bq_data.size(), 4 + CS); end
    for (int i = 0; i < bq_data.size() && i < 4 + CS; i++) begin
      exp = (i < 4) ? vals[i] : 32'hAAAA_AAAA;
      checks++;
      if (bq_data[i] !== exp || bq_last[i] !== (i == 3 + CS))
        begin errors++; $display("FAIL wrap_beat%0d: got %h/%b expected %h/%b", i, bq_data[i], bq_last[i], exp, (i == 3 + CS)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] exp;
    clear_log(); m_ready = 1'b1;
    start(11'h010, 12'd8);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bq_data.size() >= 3) begin
        m_ready = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({ram_en, ram_addr, m_valid, m_last, m_data, active, done} !== 48'h0)
      begin errors++; $display("FAIL midrst_outputs: got %h expected 0", {ram_en, ram_addr, m_valid, m_last, m_data, active, done}); end
    checks++;
    if (bq_data.size() != 3) begin errors++; $display("FAIL midrst_beats: got %0d expected 3", bq_data.size()); end
    @(posedge clk); #1 rst = 1'b0;
    clear_log(); m_ready = 1'b1;
    start(11'h010, 12'd8);
    run(60, 16'hFFFF, ok);
    checks++;
    if (!ok || bq_data.size() != 8 + CS) begin errors++; $display("FAIL midrst_rerun: got %0d beats done=%b expected %0d", bq_data.size(), ok, 8 + CS); end
    for (int i = 0; i < bq_data.size() && i < 8 + CS; i++) begin
      exp = (i < 8) ? 32'hA000_0000 + i : 32'h0000_001C;
      checks++;
      if (bq_data[i] !== exp || bq_last[i] !== (i == 7 + CS))
        begin errors++; $display("FAIL midrst_beat%0d: got %h/%b expected %h/%b", i, bq_data[i], bq_last[i], exp, (i == 7 + CS)); end
    end
  endtask

`ifdef UNLOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    logic [31:0] vals [5];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3; vals[3] = 32'hFFFF_FFFF; vals[4] = 32'h5;
    for (int i = 0; i < 4; i++) ram[256 + i] = vals[i];
    clear_log(); m_ready = 1'b1;
    start(11'h100, 12'd4);
    run(40, 16'hFFFF, ok);
    checks++;
    if (!ok || bq_data.size() != 5) begin errors++; $display("FAIL csum_beats: got %0d done=%b expected 5", bq_data.size(), ok); end
    for (int i = 0; i < bq_data.size() && i < 5; i++) begin
      checks++;
      if (bq_data[i] !== vals[i] || bq_last[i] !== (i == 4))
        begin errors++; $display("FAIL csum_beat%0d: got %h/%b expected %h/%b", i, bq_data[i], bq_last[i], vals[i], (i == 4)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef UNLOADER_CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (we_viol != 0) begin errors++; $display("FAIL ram_we_zero: got %0d nonzero cycles expected 0", we_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
